// File: rtl/spi_host_bridge_pkg.sv
// Shared register map, STATUS/CTRL bit positions and FSM encodings for the SPI host bridge.
package spi_host_bridge_pkg;

  localparam int W_CPU = 32;

  localparam logic [1:0] SPI_REG_TXDATA = 2'd0;
  localparam logic [1:0] SPI_REG_RXDATA = 2'd1;
  localparam logic [1:0] SPI_REG_STATUS = 2'd2;
  localparam logic [1:0] SPI_REG_CTRL   = 2'd3;

  localparam int STAT_TX_EMPTY   = 0;
  localparam int STAT_TX_FULL    = 1;
  localparam int STAT_RX_EMPTY   = 2;
  localparam int STAT_RX_FULL    = 3;
  localparam int STAT_BUSY       = 4;
  localparam int STAT_RX_OVF     = 5;
  localparam int STAT_TX_OVF     = 6;
  localparam int STAT_TIMEOUT    = 7;

  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_FLUSH      = 1;
  localparam int CTRL_IRQ_EN     = 2;

  localparam logic [1:0] SPI_ST_IDLE  = 2'd0;
  localparam logic [1:0] SPI_ST_LOAD  = 2'd1;
  localparam logic [1:0] SPI_ST_SHIFT = 2'd2;
  localparam logic [1:0] SPI_ST_DONE  = 2'd3;

  // Field order matches the STATUS bit numbering (bit 7 first).
  typedef struct packed {
    logic timeout_err;
    logic tx_ovf;
    logic rx_ovf;
    logic busy;
    logic rx_full;
    logic rx_empty;
    logic tx_full;
    logic tx_empty;
  } spi_status_t;

endpackage

// File: rtl/spi_host_bridge_fifo.sv
// Synchronous FIFO, head word visible combinationally on dout; push on full accepted only with a
// same-cycle pop, pop on empty ignored; flush empties it and discards a same-cycle push.
module spi_fifo #(
  parameter int W          = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]        r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;
  logic                w_do_push;
  logic                w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                     (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = r_mem[r_rptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/spi_host_bridge.sv
// CPU register window in front of the spi shifter: TX/RX FIFOs, sticky errors, handoff FSM.
// Loads return one cycle after rd_en; TXDATA stores to a full FIFO are dropped and flagged.
module spi_host_bridge
  import spi_host_bridge_pkg::*;
#(
  parameter int W_Data     = W_CPU,
  parameter int DEPTH_LOG2 = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        addr,
  input  logic              wr_en,
  input  logic [W_Data-1:0] wr_data,
  input  logic              rd_en,
  output logic [W_Data-1:0] rd_data,
  output logic              irq,
  output logic [W_Data-1:0] data_to_transmit,
  output logic              data_transmit_valid,
  input  logic              transmit_ready,
  input  logic [W_Data-1:0] data_in
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]        r_state;
  logic [TW-1:0]     r_tmo_cnt;
  logic [W_Data-1:0] r_dtt;
  logic [W_Data-1:0] r_rd_data;
  logic              r_enable;
  logic              r_irq_en;
  logic              r_rx_ovf;
  logic              r_tx_ovf;
  logic              r_timeout_err;

  logic              w_wr_tx, w_wr_stat, w_wr_ctrl, w_rd_rx, w_flush;
  logic              w_start, w_done, w_timeout;
  logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [W_Data-1:0] w_tx_dout, w_rx_dout;
  spi_status_t       w_status;

  assign w_wr_tx   = wr_en && (addr == SPI_REG_TXDATA);
  assign w_wr_stat = wr_en && (addr == SPI_REG_STATUS);
  assign w_wr_ctrl = wr_en && (addr == SPI_REG_CTRL);
  assign w_rd_rx   = rd_en && (addr == SPI_REG_RXDATA);
  assign w_flush   = w_wr_ctrl && wr_data[CTRL_FLUSH];

  assign w_start   = (r_state == SPI_ST_IDLE) && r_enable && !w_tx_empty && transmit_ready && !w_flush;
  assign w_tx_pop  = w_start;
  assign w_tx_push = w_wr_tx && (!w_tx_full || w_tx_pop);

  // Flush in the DONE cycle discards the received word.
  assign w_done    = (r_state == SPI_ST_DONE) && !w_flush;
  assign w_rx_pop  = w_rd_rx && !w_rx_empty;
  assign w_rx_push = w_done && (!w_rx_full || w_rx_pop);
  assign w_timeout = (r_state == SPI_ST_LOAD) && transmit_ready && !w_flush &&
                     (r_tmo_cnt == TW'(TIMEOUT - 1));

  spi_fifo #(.W(W_Data), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .flush (w_flush),
    .din   (wr_data),
    .dout  (w_tx_dout),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  spi_fifo #(.W(W_Data), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .flush (w_flush),
    .din   (data_in),
    .dout  (w_rx_dout),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  always_comb begin
    w_status             = '0;
    w_status.tx_empty    = w_tx_empty;
    w_status.tx_full     = w_tx_full;
    w_status.rx_empty    = w_rx_empty;
    w_status.rx_full     = w_rx_full;
    w_status.busy        = (r_state != SPI_ST_IDLE);
    w_status.rx_ovf      = r_rx_ovf;
    w_status.tx_ovf      = r_tx_ovf;
    w_status.timeout_err = r_timeout_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= SPI_ST_IDLE;
      r_tmo_cnt <= '0;
      r_dtt     <= '0;
    end else if (w_flush) begin
      r_state <= SPI_ST_IDLE;
    end else begin
      case (r_state)
        SPI_ST_IDLE: begin
          if (w_start) begin
            r_state   <= SPI_ST_LOAD;
            r_dtt     <= w_tx_dout;
            r_tmo_cnt <= '0;
          end
        end
        SPI_ST_LOAD: begin
          if (!transmit_ready)                     r_state   <= SPI_ST_SHIFT;
          else if (w_timeout)                      r_state   <= SPI_ST_IDLE;
          else if (r_tmo_cnt != TW'(TIMEOUT))      r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
        SPI_ST_SHIFT: begin
          if (transmit_ready) r_state <= SPI_ST_DONE;
        end
        default: r_state <= SPI_ST_IDLE;
      endcase
    end
  end

  // Sticky bits: a same-cycle set beats a write-1-to-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enable      <= 1'b0;
      r_irq_en      <= 1'b0;
      r_rx_ovf      <= 1'b0;
      r_tx_ovf      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= wr_data[CTRL_ENABLE];
        r_irq_en <= wr_data[CTRL_IRQ_EN];
      end
      r_rx_ovf      <= (r_rx_ovf      & ~(w_wr_stat & wr_data[STAT_RX_OVF]))  | (w_done && !w_rx_push);
      r_tx_ovf      <= (r_tx_ovf      & ~(w_wr_stat & wr_data[STAT_TX_OVF]))  | (w_wr_tx && !w_tx_push && !w_flush);
      r_timeout_err <= (r_timeout_err & ~(w_wr_stat & wr_data[STAT_TIMEOUT])) | w_timeout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      case (addr)
        SPI_REG_RXDATA: r_rd_data <= w_rx_empty ? '0 : w_rx_dout;
        SPI_REG_STATUS: r_rd_data <= {{(W_Data-8){1'b0}}, w_status};
        SPI_REG_CTRL:   r_rd_data <= {{(W_Data-3){1'b0}}, r_irq_en, 1'b0, r_enable};
        default:        r_rd_data <= '0;
      endcase
    end
  end

  assign rd_data             = r_rd_data;
  assign data_to_transmit    = r_dtt;
  assign data_transmit_valid = (r_state == SPI_ST_LOAD) || (r_state == SPI_ST_SHIFT);
  assign irq                 = r_irq_en & (!w_rx_empty | r_rx_ovf | r_tx_ovf | r_timeout_err);

endmodule

// File: tb/tb_spi_host_bridge.sv
// Directed bench for spi_host_bridge with a behavioural shifter model on the handoff interface.
module tb_spi_host_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        irq;
  logic [31:0] data_to_transmit;
  logic        data_transmit_valid;
  logic        transmit_ready;
  logic [31:0] data_in;

  int          checks   = 0;
  int          failures = 0;

  logic        m_stuck;
  logic        m_echo;
  int          m_busy;
  logic [31:0] m_fixed;
  logic [31:0] tx_log [$];

  always #5 clk = ~clk;

  spi_host_bridge dut (
    .clk                 (clk),
    .rst                 (rst),
    .addr                (addr),
    .wr_en               (wr_en),
    .wr_data             (wr_data),
    .rd_en               (rd_en),
    .rd_data             (rd_data),
    .irq                 (irq),
    .data_to_transmit    (data_to_transmit),
    .data_transmit_valid (data_transmit_valid),
    .transmit_ready      (transmit_ready),
    .data_in             (data_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rdchk(input logic [1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check(tag, rd_data, exp);
  endtask

  // Shifter model: accepts an offered word by dropping ready, then returns a word after m_busy edges.
  initial begin
    transmit_ready = 1'b1;
    data_in        = '0;
    forever begin
      @(posedge clk); #1;
      if (rst && data_transmit_valid && transmit_ready && !m_stuck) begin
        tx_log.push_back(data_to_transmit);
        transmit_ready = 1'b0;
        data_in = m_echo ? (data_to_transmit ^ 32'hFFFF_0000) : m_fixed;
        repeat (m_busy) @(posedge clk);
        #1;
        transmit_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    m_stuck = 1'b0; m_echo = 1'b0; m_busy = 32; m_fixed = 32'h1234_5678;
    repeat (3) @(negedge clk);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_valid", 32'(data_transmit_valid), 32'h0);
    check("rst_dtt", data_to_transmit, 32'h0);
    rst = 1'b1;
    rdchk(2'd2, 32'h05, "rst_status");
    rdchk(2'd3, 32'h00, "rst_ctrl");

    // Single word through the shifter
    wr(2'd3, 32'h1);
    wr(2'd0, 32'hA5A5_0001);
    check("valid_1cyc", 32'(data_transmit_valid), 32'h0);
    @(posedge clk); #1;
    check("valid_2cyc", 32'(data_transmit_valid), 32'h1);
    check("dtt_word", data_to_transmit, 32'hA5A5_0001);
    repeat (45) @(posedge clk);
    rdchk(2'd2, 32'h01, "status_rx_avail");
    rdchk(2'd1, 32'h1234_5678, "rxdata_word");
    rdchk(2'd2, 32'h05, "status_rx_drained");
    check("irq_disabled", 32'(irq), 32'h0);

    // TX overflow with the FSM disabled, then drain
    wr(2'd3, 32'h0);
    m_echo = 1'b1; m_busy = 4; base = tx_log.size();
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h11 + 32'(i));
    @(negedge clk); addr = 2'd2; rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    check("status_tx_ovf", rd_data & 32'hC3, 32'h42);
    check("status_rx_empty_bit", 32'(rd_data[2]), 32'h1);
    wr(2'd2, 32'h40);
    wr(2'd3, 32'h1);
    repeat (80) @(posedge clk);
    check("drain_count", 32'(tx_log.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) check("drain_word", tx_log[base + i], 32'h11 + 32'(i));

    // Fifth word arrives with the RX FIFO already full
    wr(2'd0, 32'h16);
    repeat (20) @(posedge clk);
    check("tx_word5", tx_log[base + 4], 32'h16);
    rdchk(2'd2, 32'h29, "status_rx_ovf");
    for (int i = 0; i < 4; i++) rdchk(2'd1, 32'hFFFF_0011 + 32'(i), "rx_order");
    rdchk(2'd1, 32'h0, "rx_empty_read");
    rdchk(2'd2, 32'h25, "status_after_reads");
    wr(2'd2, 32'h20);
    rdchk(2'd2, 32'h05, "status_rx_ovf_clr");

    // Timeout: shifter never drops ready
    m_stuck = 1'b1;
    wr(2'd0, 32'h77);
    @(posedge clk); #1;
    check("tmo_load", 32'(data_transmit_valid), 32'h1);
    repeat (63) @(posedge clk);
    #1;
    check("tmo_load_63", 32'(data_transmit_valid), 32'h1);
    @(posedge clk); #1;
    check("tmo_idle_64", 32'(data_transmit_valid), 32'h0);
    rdchk(2'd2, 32'h85, "status_timeout");
    wr(2'd2, 32'h80);
    rdchk(2'd2, 32'h05, "status_timeout_clr");
    m_stuck = 1'b0;

    // Flush with the FSM disabled
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h1);
    wr(2'd0, 32'h2);
    rdchk(2'd2, 32'h04, "status_pre_flush");
    wr(2'd3, 32'h2);
    rdchk(2'd2, 32'h05, "status_post_flush");
    rdchk(2'd3, 32'h0, "ctrl_flush_selfclr");

    // Asynchronous reset while word 2 of 3 is shifting
    m_busy = 20; base = tx_log.size();
    wr(2'd3, 32'h1);
    wr(2'd0, 32'h21); wr(2'd0, 32'h22); wr(2'd0, 32'h23);
    for (int i = 0; i < 200 && tx_log.size() != base + 2; i++) @(negedge clk);
    check("word2_started", 32'(tx_log.size() - base), 32'd2);
    repeat (2) @(posedge clk);
    rdchk(2'd2, 32'h10, "status_mid_shift");
    @(negedge clk); rst = 1'b0; #1;
    check("rst_mid_valid", 32'(data_transmit_valid), 32'h0);
    check("rst_mid_dtt", data_to_transmit, 32'h0);
    @(negedge clk); rst = 1'b1;
    rdchk(2'd2, 32'h05, "status_after_rst");
    repeat (30) @(posedge clk);

    // Interrupt on RX arrival, cleared by emptying the RX FIFO
    m_echo = 1'b0; m_fixed = 32'hCAFE_0001; m_busy = 4;
    wr(2'd3, 32'h5);
    wr(2'd0, 32'h99);
    check("irq_before_rx", 32'(irq), 32'h0);
    for (int i = 0; i < 40 && !irq; i++) @(negedge clk);
    check("irq_rise", 32'(irq), 32'h1);
    rdchk(2'd1, 32'hCAFE_0001, "irq_rx_word");
    check("irq_fall", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_host_bridge.md
# spi_host_bridge

CPU-facing front end for the `spi` shifter: it exposes a four-word register window to CPU loads and stores and buffers outgoing words in a TX FIFO. An FSM hands one word at a time to the shifter over `data_to_transmit`/`data_transmit_valid`/`transmit_ready`, and each received `data_in` word goes into an RX FIFO. The block sits directly upstream (TX) and downstream (RX) of `spi`.

## Interface
- `W_Data`, default `W_CPU`: width of SPI words and CPU data.
- `DEPTH_LOG2`, default 2: log2 of the depth of each FIFO (4 entries).
- `TIMEOUT`, default 64: cycles allowed for the shifter to drop `transmit_ready` after a word is offered.
- `clk  in  1`: system clock; also drives the `spi` instance.
- `rst  in  1`: asynchronous, active-low reset.
- `addr  in  2`: register word offset (0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL).
- `wr_en  in  1`: CPU store strobe.
- `wr_data  in  W_Data`: CPU store data.
- `rd_en  in  1`: CPU load strobe.
- `rd_data  out  W_Data`: load result, registered.
- `irq  out  1`: interrupt request, level-sensitive.
- `data_to_transmit  out  W_Data`: word offered to the shifter.
- `data_transmit_valid  out  1`: word-valid level to the shifter.
- `transmit_ready  in  1`: shifter is idle and can accept a word.
- `data_in  in  W_Data`: word received by the shifter.

## Operation
- **TXDATA write**
  - When the TX FIFO is not full, or is popped in the same cycle: push `wr_data`.
  - Otherwise: drop the word and set sticky `tx_ovf`.
- **RXDATA read**
  - When the RX FIFO is not empty: pop it and return the head word.
  - When it is empty: return 0 and do not pop.
- **STATUS read**: bit 0 `tx_empty`, 1 `tx_full`, 2 `rx_empty`, 3 `rx_full`, 4 `busy` (FSM not IDLE), 5 `rx_ovf`, 6 `tx_ovf`, 7 `timeout_err`. All other bits read 0.
- **STATUS write**: write-1-to-clear on bits 5–7.
- **CTRL**: bit 0 `enable` (R/W), bit 1 `flush` (write-only, self-clearing), bit 2 `irq_en` (R/W).
  - `flush` empties both FIFOs and returns the FSM to IDLE in the next cycle.
- **FSM**
  - IDLE → LOAD when `enable` is set, the TX FIFO is not empty, and `transmit_ready` is 1. The entry cycle pops the TX FIFO into the `data_to_transmit` register.
  - LOAD: `data_transmit_valid` = 1. Go to SHIFT on the first cycle `transmit_ready` is 0. If `TIMEOUT` cycles pass first, set `timeout_err` and go to IDLE.
  - SHIFT: `data_transmit_valid` stays 1 and `data_to_transmit` stays stable. On the first cycle `transmit_ready` is 1, go to DONE.
  - DONE: push `data_in` into the RX FIFO. If the RX FIFO is full, drop the word and set `rx_ovf`. Deassert valid and go to IDLE.
- `irq` = `irq_en` & (`!rx_empty` | `rx_ovf` | `tx_ovf` | `timeout_err`).
- Clearing `enable` mid-word does not abort that word; it only blocks the next IDLE→LOAD.

## Timing
- **Reset values**: `rd_data`=0, `irq`=0, `data_to_transmit`=0, `data_transmit_valid`=0. FSM in IDLE, both FIFOs empty, CTRL=0, sticky bits 0.
- **Load latency**: `rd_data` is valid the cycle after `rd_en`. The RX pop takes effect on the `rd_en` edge.
- **Same-cycle `wr_en` and `rd_en`**: both are serviced.
- **Store to TXDATA → `data_transmit_valid` high**: 2 cycles minimum (push, then IDLE→LOAD pop).
- **Back-to-back words**: at least 1 idle cycle between words (DONE→IDLE→LOAD).
- **FIFO pointers**: `DEPTH_LOG2`+1 bits wide, so wrap-around needs no special case; full = MSBs differ and LSBs equal.
- **Same-cycle push/pop**
  - On a full FIFO: accepted, count unchanged.
  - On an empty FIFO: push only; data is not bypassed.
- **Timeout counter**: `$clog2(TIMEOUT+1)` bits, cleared on LOAD entry, saturates.
- **`flush` in the same cycle as DONE**: `flush` wins; the RX push is discarded.
- **Reset mid-word**: all state returns to reset values immediately (asynchronous).

## Structure
- Shared package or header (`lib/`):
  - register offsets: `SPI_REG_TXDATA`, `SPI_REG_RXDATA`, `SPI_REG_STATUS`, `SPI_REG_CTRL`;
  - STATUS and CTRL bit indices;
  - FSM state encodings: `SPI_ST_IDLE`, `SPI_ST_LOAD`, `SPI_ST_SHIFT`, `SPI_ST_DONE`.
- Sub-module `spi_fifo`: synchronous FIFO with parameters `W`, `DEPTH_LOG2` and signals push/pop/flush/full/empty/dout. It is instantiated twice (TX and RX).
- The bridge top contains the register decode, sticky bits, FSM and timeout counter.

## Test plan
- Reset, then write CTRL=1 and TXDATA=`32'hA5A5_0001`, with a shifter model that drops ready for 32 cycles and returns `data_in`=`32'h1234_5678`.
  - `data_transmit_valid` rises 2 cycles after the write.
  - RXDATA then reads `32'h1234_5678` and STATUS bit 2 = 1.
- With `enable`=0, write 5 words into the 4-deep TX FIFO.
  - STATUS = `0x42` (`tx_full`, `tx_ovf`).
  - The 5th word is absent when the FIFO drains after `enable`=1.
- Model holds `transmit_ready` high forever.
  - After 64 cycles in LOAD, `timeout_err` = 1 and the FSM is IDLE.
  - Writing STATUS=`0x80` clears it.
- Send 5 words without reading RXDATA.
  - `rx_full` = 1 and `rx_ovf` = 1.
  - Four reads return words 1–4 in order; the 5th read returns 0.
- Assert `rst` low during SHIFT of word 2 of 3.
  - `data_transmit_valid` = 0 immediately and STATUS reads `0x05`.
- With `irq_en`=1, `irq` rises when the first RX word lands and falls after the RXDATA read that empties the RX FIFO.
